// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, request owners and the latched request.
package mem_arb_pkg;

    localparam int ARB_ADDR_W = 64;
    localparam int ARB_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Encoding matches the grant bit position: [0] IFU, [1] LSU read, [2] LSU write.
    typedef enum logic [1:0] {
        OWN_IFU    = 2'd0,
        OWN_LSU_RD = 2'd1,
        OWN_LSU_WR = 2'd2
    } arb_owner_t;

    typedef struct packed {
        arb_owner_t              owner;
        logic                    write;
        logic [ARB_ADDR_W-1:0]   address;
        logic [ARB_DATA_W-1:0]   wdata;
        logic [ARB_DATA_W-1:0]   wmask;
    } arb_req_t;

    function automatic arb_owner_t grant_to_owner(input logic [2:0] grant);
        if (grant[2]) return OWN_LSU_WR;
        if (grant[1]) return OWN_LSU_RD;
        return OWN_IFU;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and downstream memory signals of the arbiter; slave = arbiter view, master = requesters/memory view.
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic                  ifu_read_valid;
    logic                  ifu_read_ready;
    logic [ARB_ADDR_W-1:0] ifu_read_address;
    logic                  ifu_read_done;
    logic [ARB_DATA_W-1:0] ifu_read_data;

    logic                  lsu_read_valid;
    logic                  lsu_read_ready;
    logic [ARB_ADDR_W-1:0] lsu_read_address;
    logic                  lsu_read_done;
    logic [ARB_DATA_W-1:0] lsu_read_data;

    logic                  lsu_write_valid;
    logic                  lsu_write_ready;
    logic [ARB_ADDR_W-1:0] lsu_write_address;
    logic [ARB_DATA_W-1:0] lsu_write_data;
    logic [ARB_DATA_W-1:0] lsu_write_mask;
    logic                  lsu_write_done;

    logic                  mem_valid;
    logic                  mem_ready;
    logic                  mem_write;
    logic [ARB_ADDR_W-1:0] mem_address;
    logic [ARB_DATA_W-1:0] mem_wdata;
    logic [ARB_DATA_W-1:0] mem_wmask;
    logic                  mem_done;
    logic [ARB_DATA_W-1:0] mem_rdata;

    modport slave (
        input  ifu_read_valid, ifu_read_address,
        output ifu_read_ready, ifu_read_done, ifu_read_data,
        input  lsu_read_valid, lsu_read_address,
        output lsu_read_ready, lsu_read_done, lsu_read_data,
        input  lsu_write_valid, lsu_write_address, lsu_write_data, lsu_write_mask,
        output lsu_write_ready, lsu_write_done,
        output mem_valid, mem_write, mem_address, mem_wdata, mem_wmask,
        input  mem_ready, mem_done, mem_rdata
    );

    modport master (
        output ifu_read_valid, ifu_read_address,
        input  ifu_read_ready, ifu_read_done, ifu_read_data,
        output lsu_read_valid, lsu_read_address,
        input  lsu_read_ready, lsu_read_done, lsu_read_data,
        output lsu_write_valid, lsu_write_address, lsu_write_data, lsu_write_mask,
        input  lsu_write_ready, lsu_write_done,
        input  mem_valid, mem_write, mem_address, mem_wdata, mem_wmask,
        output mem_ready, mem_done, mem_rdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational requester picker: fixed priority LSU write > LSU read > IFU,
// overridden in favour of a waiting IFU once it has lost STARVE_LIMIT times in a row.
module mem_arb_pick #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             ifu_valid_i,
    input  logic             lsu_rd_valid_i,
    input  logic             lsu_wr_valid_i,
    input  logic [CNT_W-1:0] starve_cnt_i,
    output logic [2:0]       grant_o
);

    always_comb begin
        grant_o = 3'b000;
        if (ifu_valid_i && (starve_cnt_i == CNT_W'(STARVE_LIMIT))) begin
            grant_o = 3'b001;
        end else if (lsu_wr_valid_i) begin
            grant_o = 3'b100;
        end else if (lsu_rd_valid_i) begin
            grant_o = 3'b010;
        end else if (ifu_valid_i) begin
            grant_o = 3'b001;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding memory port shared by IFU read, LSU read and LSU write.
// FSM | IDLE: accept one requester | ISSUE: drive mem request | WAIT: await mem_done | RESP: pulse owner's done
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t            state_q, state_d;
    arb_req_t              req_q, req_d;
    logic [CNT_W-1:0]      starve_q, starve_d;
    logic [ARB_DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
    logic [ARB_DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;

    logic [2:0] grant;
    logic [2:0] ready_vec;
    logic       in_issue;
    logic       in_resp;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_pick (
        .ifu_valid_i    (bus.ifu_read_valid),
        .lsu_rd_valid_i (bus.lsu_read_valid),
        .lsu_wr_valid_i (bus.lsu_write_valid),
        .starve_cnt_i   (starve_q),
        .grant_o        (grant)
    );

    // Ready is qualified with rst_n so nothing is accepted while reset is held.
    assign ready_vec = ((state_q == IDLE) && rst_n) ? grant : 3'b000;
    assign in_issue  = (state_q == ISSUE);
    assign in_resp   = (state_q == RESP);

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        starve_d    = starve_q;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        case (state_q)
            IDLE: begin
                if (|ready_vec) begin
                    req_d.owner   = grant_to_owner(ready_vec);
                    req_d.write   = ready_vec[2];
                    req_d.address = ready_vec[2] ? bus.lsu_write_address :
                                    ready_vec[1] ? bus.lsu_read_address  :
                                                   bus.ifu_read_address;
                    req_d.wdata   = ready_vec[2] ? bus.lsu_write_data : '0;
                    req_d.wmask   = ready_vec[2] ? bus.lsu_write_mask : '0;
                    if (ready_vec[0]) begin
                        starve_d = '0;
                    end else if (bus.ifu_read_valid && (starve_q != CNT_W'(STARVE_LIMIT))) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_ready) state_d = WAIT;
            end
            WAIT: begin
                if (bus.mem_done) begin
                    if (!req_q.write) begin
                        if (req_q.owner == OWN_IFU) ifu_rdata_d = bus.mem_rdata;
                        else                        lsu_rdata_d = bus.mem_rdata;
                    end
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            starve_q    <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            starve_q    <= starve_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    assign bus.ifu_read_ready  = ready_vec[0];
    assign bus.lsu_read_ready  = ready_vec[1];
    assign bus.lsu_write_ready = ready_vec[2];

    assign bus.ifu_read_done  = in_resp && (req_q.owner == OWN_IFU);
    assign bus.lsu_read_done  = in_resp && (req_q.owner == OWN_LSU_RD);
    assign bus.lsu_write_done = in_resp && (req_q.owner == OWN_LSU_WR);

    assign bus.ifu_read_data = ifu_rdata_q;
    assign bus.lsu_read_data = lsu_rdata_q;

    assign bus.mem_valid   = in_issue;
    assign bus.mem_write   = in_issue && req_q.write;
    assign bus.mem_address = in_issue ? req_q.address : '0;
    assign bus.mem_wdata   = in_issue ? req_q.wdata   : '0;
    assign bus.mem_wmask   = in_issue ? req_q.wmask   : '0;

endmodule
